fifo1c_drain: RTL

FIFO1C_DRAIN -- requirements
Module: fifo1c_drain

---
 rtl/fifo1c_pkg.sv | 18 +
 rtl/drain_skid_buf.sv | 67 ++++++
 rtl/fifo1c_drain.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fifo1c_pkg.sv
// Shared types and constants for the FIFO drain block.
package fifo1c_pkg;

    localparam int DEF_DATA_WIDTH = 144;
    localparam int STAT_W         = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } drain_state_e;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// Circular output buffer: registered storage, read port driven straight from
// the entry at the read pointer so the stream output has no path from din.
module drain_skid_buf
    import fifo1c_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [PTR_W-1:0]                 wr_ptr;
    logic [PTR_W-1:0]                 rd_ptr;
    logic                             do_push;
    logic                             do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // A push into a full buffer is only accepted when a pop frees a slot in
    // the same cycle; a pop from an empty buffer is ignored.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy tracking; clr drops every stored entry.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; cleared on reset so the idle output reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '0;
        end else if (do_push && !clr) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/fifo1c_drain.sv
// Drains a fixed-latency source FIFO into a valid/ready stream. Reads are
// issued only when the buffer has room for every outstanding word, so data
// returning from the FIFO is always accepted. Flush drops buffered words and
// swallows the replies of reads already in flight.
module fifo1c_drain
    import fifo1c_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_LAT     = 1,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    output logic                  fifo_rdreq,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  flush,
    output logic                  busy,
    input  logic                  cnt_clr,
    output logic [STAT_W-1:0]     word_cnt,
    output logic [STAT_W-1:0]     stall_cnt
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
    localparam int OCC_W = $clog2(BUF_DEPTH + RD_LAT) + 1;

    drain_state_e      state;
    drain_state_e      state_nxt;

    // vld_pipe[0] is the read issued this cycle; vld_pipe[RD_LAT] marks the
    // cycle in which its data is on fifo_q.
    logic [RD_LAT:0]   vld_pipe;
    logic [RD_LAT:1]   vld_q;
    logic [OCC_W-1:0]  infl;
    logic              any_infl;
    logic [OCC_W-1:0]  occ;

    logic [CNT_W-1:0]  buf_cnt;
    logic              buf_push;
    logic              buf_pop;
    logic              buf_clr;
    logic              flush_take;
    logic              xfer;
    logic              stall;

    logic [STAT_W-1:0] word_cnt_r;
    logic [STAT_W-1:0] stall_cnt_r;

    assign vld_pipe = {vld_q, fifo_rdreq};
    assign any_infl = |vld_q;

    // Count of reads issued whose data has not yet been written to the buffer.
    always_comb begin
        infl = '0;
        for (int i = 1; i <= RD_LAT; i++) begin
            infl = infl + OCC_W'(vld_q[i]);
        end
    end

    assign occ = OCC_W'(buf_cnt) + infl;

    // Flush only takes effect from IDLE/RUN; a repeat while flushing is ignored.
    assign flush_take = flush && (state != ST_FLUSH);

    assign fifo_rdreq = !rst && !fifo_empty && (state != ST_FLUSH) && !flush &&
                        (occ < OCC_W'(BUF_DEPTH));

    // Output comes from buffer registers only.
    assign out_valid = (buf_cnt != '0);
    assign xfer      = out_valid && out_ready && (state != ST_FLUSH);
    assign stall     = out_valid && !out_ready;

    // Returning words are dropped during the flush cycle and the FLUSH state.
    assign buf_push = vld_q[RD_LAT] && (state != ST_FLUSH) && !flush_take;
    assign buf_pop  = xfer;
    assign buf_clr  = flush_take;

    drain_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .clr   (buf_clr),
        .push  (buf_push),
        .pop   (buf_pop),
        .din   (fifo_q),
        .dout  (out_data),
        .count (buf_cnt)
    );

    // In-flight read tracking: one valid bit per cycle of FIFO read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_pipe[RD_LAT-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and busy flag.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (flush_take) begin
                    state_nxt = ST_FLUSH;
                end else if (fifo_rdreq) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush_take) begin
                    state_nxt = ST_FLUSH;
                end else if ((buf_cnt == '0) && !any_infl && !fifo_rdreq) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                busy = 1'b1;
                if (!any_infl) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Statistics: saturating, clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            word_cnt_r  <= '0;
            stall_cnt_r <= '0;
        end else begin
            if (xfer)  word_cnt_r  <= sat_inc(word_cnt_r);
            if (stall) stall_cnt_r <= sat_inc(stall_cnt_r);
        end
    end

    assign word_cnt  = word_cnt_r;
    assign stall_cnt = stall_cnt_r;

endmodule
